// File: rtl/data_access_unit_pkg.sv
// Shared encodings and size helpers for the load/store data access unit.
package data_access_unit_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BEAT0 = 2'd1;
   localparam logic [1:0] ST_BEAT1 = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   // The unused encoding 2'b11 is handled as a word everywhere.
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SIZE_BYTE: return 3'd1;
         SIZE_HALF: return 3'd2;
         default:   return 3'd4;
      endcase
   endfunction

   function automatic logic [3:0] size_mask(input logic [1:0] size);
      case (size)
         SIZE_BYTE: return 4'b0001;
         SIZE_HALF: return 4'b0011;
         default:   return 4'b1111;
      endcase
   endfunction

   function automatic logic is_split(input logic [1:0] offset, input logic [1:0] size);
      return ({1'b0, offset} + size_bytes(size)) > 3'd4;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] offset, input logic [1:0] size);
      case (size)
         SIZE_BYTE: return 1'b0;
         SIZE_HALF: return offset[0];
         default:   return offset != 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/data_access_unit_lane_align.sv
// Combinational lane steering: byte enables and shifted store data per beat,
// plus merge/shift/extend of one or two returned words into the load result.
module data_access_unit_lane_align
   import data_access_unit_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic        second_beat,
   input  logic [31:0] write_data,
   input  logic [31:0] read_hi,
   input  logic [31:0] read_lo,
   input  logic        is_unsigned,
   output logic [3:0]  byte_enable,
   output logic [31:0] lane_write_data,
   output logic [31:0] load_data
);

   logic [2:0]  back_shift;
   logic [31:0] raw;
   logic        sign_bit;

   always_comb begin
      back_shift = 3'd4 - {1'b0, offset};
      // The second beat carries the bytes that spilled past the first word.
      if (second_beat) begin
         byte_enable     = size_mask(size) >> back_shift;
         lane_write_data = write_data >> {back_shift, 3'b000};
      end else begin
         byte_enable     = 4'(size_mask(size) << offset);
         lane_write_data = write_data << {offset, 3'b000};
      end

      raw      = 32'({read_hi, read_lo} >> {offset, 3'b000});
      sign_bit = 1'b0;
      case (size)
         SIZE_BYTE: begin
            sign_bit  = raw[7] & ~is_unsigned;
            load_data = {{24{sign_bit}}, raw[7:0]};
         end
         SIZE_HALF: begin
            sign_bit  = raw[15] & ~is_unsigned;
            load_data = {{16{sign_bit}}, raw[15:0]};
         end
         default: load_data = raw;
      endcase
   end

endmodule

// File: rtl/data_access_unit.sv
// Load/store sequencer: accepts one request, issues one or two word beats on the
// data bus, and returns the merged, extended load result as a one-cycle response.
module data_access_unit
   import data_access_unit_pkg::*;
#(
   parameter bit SUPPORT_MISALIGNED = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_address,
   input  logic [31:0] req_write_data,
   output logic        resp_valid,
   output logic        resp_error,
   output logic [31:0] resp_read_data,
   output logic [31:0] bus_address,
   output logic [31:0] bus_write_data,
   output logic [3:0]  bus_byte_enable,
   output logic        bus_read_enable,
   output logic        bus_write_enable,
   input  logic [31:0] bus_read_data
);

   logic [1:0]  state_reg, state_next;
   logic        write_reg;
   logic [1:0]  size_reg;
   logic        unsigned_reg;
   logic [31:0] address_reg;
   logic [31:0] wdata_reg;
   logic [31:0] lo_reg;
   logic        error_reg;

   logic        accept;
   logic        reject;
   logic        split;
   logic        in_beat;
   logic [31:0] word_address;
   logic [31:0] read_hi, read_lo;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata;
   logic [31:0] load_data;

   assign accept       = (state_reg == ST_IDLE) && req_valid;
   assign reject       = is_misaligned(req_address[1:0], req_size) && !SUPPORT_MISALIGNED;
   assign split        = is_split(address_reg[1:0], size_reg);
   assign in_beat      = (state_reg == ST_BEAT0) || (state_reg == ST_BEAT1);
   assign word_address = {address_reg[31:2], 2'b00};

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (req_valid) state_next = reject ? ST_RESP : ST_BEAT0;
         ST_BEAT0: state_next = split ? ST_BEAT1 : ST_RESP;
         ST_BEAT1: state_next = ST_RESP;
         ST_RESP:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         write_reg    <= 1'b0;
         size_reg     <= SIZE_BYTE;
         unsigned_reg <= 1'b0;
         address_reg  <= '0;
         wdata_reg    <= '0;
         lo_reg       <= '0;
         error_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            write_reg    <= req_write;
            size_reg     <= req_size;
            unsigned_reg <= req_unsigned;
            address_reg  <= req_address;
            wdata_reg    <= req_write_data;
            error_reg    <= reject;
         end
         // Data for the first beat's address arrives during BEAT1.
         if (state_reg == ST_BEAT1) lo_reg <= bus_read_data;
      end
   end

   // In RESP the live bus word is the low word for single beats, the high word for splits.
   assign read_hi = split ? bus_read_data : 32'h0;
   assign read_lo = split ? lo_reg : bus_read_data;

   data_access_unit_lane_align u_lane_align (
      .size            (size_reg),
      .offset          (address_reg[1:0]),
      .second_beat     (state_reg == ST_BEAT1),
      .write_data      (wdata_reg),
      .read_hi         (read_hi),
      .read_lo         (read_lo),
      .is_unsigned     (unsigned_reg),
      .byte_enable     (lane_be),
      .lane_write_data (lane_wdata),
      .load_data       (load_data)
   );

   always_comb begin
      req_ready        = (state_reg == ST_IDLE);
      resp_valid       = (state_reg == ST_RESP);
      resp_error       = (state_reg == ST_RESP) && error_reg;
      resp_read_data   = '0;
      bus_address      = '0;
      bus_write_data   = '0;
      bus_byte_enable  = '0;
      bus_read_enable  = 1'b0;
      bus_write_enable = 1'b0;
      if ((state_reg == ST_RESP) && !write_reg && !error_reg) resp_read_data = load_data;
      if (in_beat) begin
         bus_address      = (state_reg == ST_BEAT1) ? word_address + 32'd4 : word_address;
         bus_write_data   = write_reg ? lane_wdata : 32'h0;
         bus_byte_enable  = lane_be;
         bus_read_enable  = !write_reg;
         bus_write_enable = write_reg;
      end
   end

endmodule

// File: tb/tb_data_access_unit.sv
// Self-checking bench: byte-addressed bus memory, byte-level reference model,
// directed cases plus randomized loads/stores.
module tb_data_access_unit;
   import data_access_unit_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0, req_valid_b = 1'b0;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_address = '0;
   logic [31:0] req_write_data = '0;
   logic        req_ready, resp_valid, resp_error;
   logic [31:0] resp_read_data;
   logic [31:0] bus_address, bus_write_data;
   logic [3:0]  bus_byte_enable;
   logic        bus_read_enable, bus_write_enable;
   logic [31:0] bus_read_data = '0;
   logic        req_ready_b, resp_valid_b, resp_error_b;
   logic [31:0] resp_read_data_b, bus_address_b, bus_write_data_b;
   logic [3:0]  bus_byte_enable_b;
   logic        bus_read_enable_b, bus_write_enable_b;
   logic [31:0] bus_read_data_b = '0;

   int n_cmp = 0;
   int n_bad = 0;
   int beats_b = 0;

   always #5 clock = ~clock;

   data_access_unit #(.SUPPORT_MISALIGNED(1'b1)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_address(req_address), .req_write_data(req_write_data),
      .resp_valid(resp_valid), .resp_error(resp_error), .resp_read_data(resp_read_data),
      .bus_address(bus_address), .bus_write_data(bus_write_data),
      .bus_byte_enable(bus_byte_enable), .bus_read_enable(bus_read_enable),
      .bus_write_enable(bus_write_enable), .bus_read_data(bus_read_data));

   data_access_unit #(.SUPPORT_MISALIGNED(1'b0)) dut_b (
      .clock(clock), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_address(req_address), .req_write_data(req_write_data),
      .resp_valid(resp_valid_b), .resp_error(resp_error_b), .resp_read_data(resp_read_data_b),
      .bus_address(bus_address_b), .bus_write_data(bus_write_data_b),
      .bus_byte_enable(bus_byte_enable_b), .bus_read_enable(bus_read_enable_b),
      .bus_write_enable(bus_write_enable_b), .bus_read_data(bus_read_data_b));

   // Bus-side memory, byte addressed, with a deterministic background pattern.
   logic [7:0] bus_mem [logic [31:0]];
   logic [7:0] ref_mem [logic [31:0]];

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        write;
   } beat_t;
   beat_t beat_log[$];

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      return a[7:0] ^ (a[15:8] * 8'd3) ^ 8'h5C;
   endfunction

   function automatic logic [7:0] bus_byte(input logic [31:0] a);
      return bus_mem.exists(a) ? bus_mem[a] : init_byte(a);
   endfunction

   function automatic logic [7:0] ref_byte(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
   endfunction

   always @(posedge clock) begin
      if (bus_read_enable || bus_write_enable)
         beat_log.push_back('{bus_address, bus_byte_enable, bus_write_data, bus_write_enable});
      if (bus_write_enable)
         for (int i = 0; i < 4; i++)
            if (bus_byte_enable[i]) bus_mem[bus_address + 32'(i)] = bus_write_data[8*i +: 8];
      if (bus_read_enable)
         bus_read_data <= {bus_byte(bus_address + 32'd3), bus_byte(bus_address + 32'd2),
                           bus_byte(bus_address + 32'd1), bus_byte(bus_address)};
      else
         bus_read_data <= $urandom;
      if (bus_read_enable_b || bus_write_enable_b) beats_b <= beats_b + 1;
   end

   // Reference: an access is n consecutive little-endian bytes in a flat memory.
   function automatic int size_n(input logic [1:0] sz);
      return (sz == SIZE_BYTE) ? 1 : (sz == SIZE_HALF) ? 2 : 4;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input bit u);
      logic [31:0] v;
      int n;
      n = size_n(sz);
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_byte(a + 32'(i));
      if (!u && n < 4 && v[8*n-1])
         for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
      return v;
   endfunction

   task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
      for (int i = 0; i < size_n(sz); i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
   endtask

   function automatic bit crosses(input logic [31:0] a, input logic [1:0] sz);
      logic [31:0] last;
      last = a + 32'(size_n(sz) - 1);
      return a[31:2] != last[31:2];
   endfunction

   // One request on either unit; reports response data/error, cycles to resp_valid, beats issued.
   task automatic run_req(input bit use_b, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int lat,
                          output int beats, output int first_beat);
      int guard;
      int b0, bb0;
      guard = 0;
      @(negedge clock);
      while (!(use_b ? req_ready_b : req_ready) && guard < 20) begin
         @(negedge clock);
         guard++;
      end
      req_write = w; req_size = sz; req_unsigned = u; req_address = a; req_write_data = wd;
      if (use_b) req_valid_b = 1'b1; else req_valid = 1'b1;
      b0 = beat_log.size();
      bb0 = beats_b;
      first_beat = b0;
      rd = 'x; err = 1'bx; lat = -1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clock);
         req_valid = 1'b0; req_valid_b = 1'b0;
         req_address = $urandom; req_write_data = $urandom; req_size = 2'($urandom);
         if (use_b ? resp_valid_b : resp_valid) begin
            lat = c;
            rd  = use_b ? resp_read_data_b : resp_read_data;
            err = use_b ? resp_error_b : resp_error;
            break;
         end
      end
      beats = use_b ? (beats_b - bb0) : (beat_log.size() - b0);
      if (lat < 0) begin
         n_cmp++; n_bad++;
         $display("FAIL resp_timeout addr=%08h: no resp_valid within 8 cycles, required one", a);
      end
   endtask

   task automatic check_access(input string name, input logic w, input logic [1:0] sz, input logic u,
                               input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] rd, exp;
      logic err;
      int lat, beats, fb, exp_lat;
      exp = w ? 32'h0 : ref_load(a, sz, u);
      exp_lat = crosses(a, sz) ? 3 : 2;
      run_req(1'b0, w, sz, u, a, wd, rd, err, lat, beats, fb);
      if (w) ref_store(a, sz, wd);
      n_cmp++;
      if (rd !== exp || err !== 1'b0 || lat !== exp_lat || beats !== exp_lat - 1) begin
         n_bad++;
         $display("FAIL %s a=%08h w=%0d sz=%0d: got data=%08h err=%b lat=%0d beats=%0d, required data=%08h err=0 lat=%0d beats=%0d",
                  name, a, w, sz, rd, err, lat, beats, exp, exp_lat, exp_lat - 1);
      end else
         $display("ok %s a=%08h w=%0d sz=%0d data=%08h lat=%0d", name, a, w, sz, rd, lat);
   endtask

   task automatic check_beat(input string name, input int idx, input logic [31:0] a,
                             input logic [3:0] be, input logic [31:0] wd, input logic w);
      n_cmp++;
      if (idx >= beat_log.size()) begin
         n_bad++;
         $display("FAIL %s: beat %0d missing, required addr=%08h be=%h", name, idx, a, be);
      end else if (beat_log[idx].addr !== a || beat_log[idx].be !== be ||
                   beat_log[idx].write !== w || (w && beat_log[idx].wdata !== wd)) begin
         n_bad++;
         $display("FAIL %s: got addr=%08h be=%h wdata=%08h we=%b, required addr=%08h be=%h wdata=%08h we=%b",
                  name, beat_log[idx].addr, beat_log[idx].be, beat_log[idx].wdata, beat_log[idx].write,
                  a, be, wd, w);
      end else
         $display("ok %s addr=%08h be=%h", name, a, be);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      n_cmp++;
      if ({req_ready, resp_valid, resp_error, resp_read_data} !== {3'b100, 32'h0}) begin
         n_bad++;
         $display("FAIL reset_resp: got ready=%b valid=%b err=%b data=%08h, required 1 0 0 00000000",
                  req_ready, resp_valid, resp_error, resp_read_data);
      end
      n_cmp++;
      if ({bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable} !== '0) begin
         n_bad++;
         $display("FAIL reset_bus: got addr=%08h wd=%08h be=%h re=%b we=%b, required all 0",
                  bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable);
      end
      n_cmp++;
      if (req_ready_b !== 1'b1 || resp_valid_b !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_b: got ready=%b valid=%b, required 1 0", req_ready_b, resp_valid_b);
      end
      reset = 1'b0;
      $display("ok reset");
   endtask

   task automatic test_word_and_byte();
      int b;
      b = beat_log.size();
      check_access("sw_aligned", 1'b1, SIZE_WORD, 1'b0, 32'h1000, 32'hDEADBEEF);
      check_beat("sw_aligned_beat", b, 32'h1000, 4'hF, 32'hDEADBEEF, 1'b1);
      b = beat_log.size();
      check_access("lw_aligned", 1'b0, SIZE_WORD, 1'b0, 32'h1000, 32'h0);
      check_beat("lw_aligned_beat", b, 32'h1000, 4'hF, 32'h0, 1'b0);
      b = beat_log.size();
      check_access("sb_0x80", 1'b1, SIZE_BYTE, 1'b0, 32'h1003, 32'h00000080);
      check_beat("sb_beat", b, 32'h1000, 4'h8, 32'h80000000, 1'b1);
      check_access("lb_signed", 1'b0, SIZE_BYTE, 1'b0, 32'h1003, 32'h0);
      check_access("lbu", 1'b0, SIZE_BYTE, 1'b1, 32'h1003, 32'h0);
   endtask

   task automatic test_half();
      int b;
      b = beat_log.size();
      check_access("sh_off2", 1'b1, SIZE_HALF, 1'b0, 32'h1002, 32'h1234ABCD);
      check_beat("sh_off2_beat", b, 32'h1000, 4'hC, 32'hABCD0000, 1'b1);
      b = beat_log.size();
      check_access("lh_off1", 1'b0, SIZE_HALF, 1'b0, 32'h1001, 32'h0);
      check_beat("lh_off1_beat", b, 32'h1000, 4'h6, 32'h0, 1'b0);
      check_access("lw_after_sh", 1'b0, SIZE_WORD, 1'b0, 32'h1000, 32'h0);
   endtask

   task automatic test_split();
      int b;
      check_access("sw_lo", 1'b1, SIZE_WORD, 1'b0, 32'h1000, 32'h44332211);
      check_access("sw_hi", 1'b1, SIZE_WORD, 1'b0, 32'h1004, 32'h88776655);
      b = beat_log.size();
      check_access("lw_split", 1'b0, SIZE_WORD, 1'b0, 32'h1001, 32'h0);
      check_beat("lw_split_b0", b, 32'h1000, 4'hE, 32'h0, 1'b0);
      check_beat("lw_split_b1", b + 1, 32'h1004, 4'h1, 32'h0, 1'b0);
      b = beat_log.size();
      check_access("sw_split", 1'b1, SIZE_WORD, 1'b0, 32'h1001, 32'hAABBCCDD);
      check_beat("sw_split_b0", b, 32'h1000, 4'hE, 32'hBBCCDD00, 1'b1);
      check_beat("sw_split_b1", b + 1, 32'h1004, 4'h1, 32'h000000AA, 1'b1);
      check_access("lw_lo_after", 1'b0, SIZE_WORD, 1'b0, 32'h1000, 32'h0);
      check_access("lw_hi_after", 1'b0, SIZE_WORD, 1'b0, 32'h1004, 32'h0);
      b = beat_log.size();
      check_access("sh_wrap", 1'b1, SIZE_HALF, 1'b0, 32'hFFFFFFFF, 32'h0000C3A5);
      check_beat("sh_wrap_b1", b + 1, 32'h00000000, 4'h1, 32'h000000C3, 1'b1);
      check_access("lw_wrap", 1'b0, SIZE_WORD, 1'b0, 32'hFFFFFFFE, 32'h0);
   endtask

   task automatic test_no_misaligned();
      logic [31:0] rd;
      logic err;
      int lat, beats, fb;
      run_req(1'b1, 1'b0, SIZE_HALF, 1'b0, 32'h1001, 32'h0, rd, err, lat, beats, fb);
      n_cmp++;
      if (err !== 1'b1 || lat !== 1 || beats !== 0 || rd !== 32'h0) begin
         n_bad++;
         $display("FAIL b_lh_misaligned: got err=%b lat=%0d beats=%0d data=%08h, required 1 1 0 00000000",
                  err, lat, beats, rd);
      end else $display("ok b_lh_misaligned");
      run_req(1'b1, 1'b1, SIZE_WORD, 1'b0, 32'h2002, 32'h12345678, rd, err, lat, beats, fb);
      n_cmp++;
      if (err !== 1'b1 || lat !== 1 || beats !== 0) begin
         n_bad++;
         $display("FAIL b_sw_misaligned: got err=%b lat=%0d beats=%0d, required 1 1 0", err, lat, beats);
      end else $display("ok b_sw_misaligned");
      run_req(1'b1, 1'b0, SIZE_BYTE, 1'b0, 32'h1003, 32'h0, rd, err, lat, beats, fb);
      n_cmp++;
      if (err !== 1'b0 || lat !== 2 || beats !== 1 || rd !== 32'h0) begin
         n_bad++;
         $display("FAIL b_lb_ok: got err=%b lat=%0d beats=%0d data=%08h, required 0 2 1 00000000",
                  err, lat, beats, rd);
      end else $display("ok b_lb_ok");
   endtask

   task automatic test_reset_mid_split();
      bit seen;
      @(negedge clock);
      req_write = 1'b1; req_size = SIZE_WORD; req_unsigned = 1'b0;
      req_address = 32'h1011; req_write_data = 32'h11223344; req_valid = 1'b1;
      @(negedge clock);
      req_valid = 1'b0;
      reset = 1'b1;  // sampled at the edge that would start the second beat
      @(negedge clock);
      reset = 1'b0;
      n_cmp++;
      if (req_ready !== 1'b1 || bus_write_enable !== 1'b0 || resp_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_reset_idle: got ready=%b we=%b valid=%b, required 1 0 0",
                  req_ready, bus_write_enable, resp_valid);
      end else $display("ok mid_reset_idle");
      seen = 1'b0;
      repeat (4) begin
         @(negedge clock);
         if (resp_valid) seen = 1'b1;
      end
      n_cmp++;
      if (seen) begin
         n_bad++;
         $display("FAIL mid_reset_resp: got resp_valid=1 after reset, required none");
      end
      ref_mem[32'h1011] = 8'h44; ref_mem[32'h1012] = 8'h33; ref_mem[32'h1013] = 8'h22;
      check_access("lw_beat0_written", 1'b0, SIZE_WORD, 1'b0, 32'h1010, 32'h0);
      check_access("lw_beat1_untouched", 1'b0, SIZE_WORD, 1'b0, 32'h1014, 32'h0);
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [1:0] sz;
      for (int i = 0; i < 150; i++) begin
         sz = 2'($urandom_range(0, 2));
         a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 + $urandom_range(0, 15)
                                          : 32'h1000 + $urandom_range(0, 47);
         check_access("random", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      end
   endtask

   task automatic test_memory_image();
      foreach (ref_mem[k]) begin
         n_cmp++;
         if (bus_byte(k) !== ref_mem[k]) begin
            n_bad++;
            $display("FAIL mem_image @%08h: got %02h, required %02h", k, bus_byte(k), ref_mem[k]);
         end
      end
      $display("ok memory image swept");
   endtask

   initial begin
      test_reset();
      test_word_and_byte();
      test_half();
      test_split();
      test_no_misaligned();
      test_reset_mid_split();
      test_random();
      test_memory_image();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
